// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: instruction field layout,
// sequencer state encoding and control-instruction decode helpers.
package cpu_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int INSTR_W_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  localparam logic [1:0] OP_CTRL  = 2'b11;
  localparam int         HALT_BIT = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_e;

  function automatic logic is_ctrl(input logic [INSTR_W_DEF-1:0] word);
    return word[INSTR_W_DEF-1 -: 2] == OP_CTRL;
  endfunction

  function automatic logic is_halt(input logic [INSTR_W_DEF-1:0] word);
    return is_ctrl(word) && word[HALT_BIT];
  endfunction

  function automatic logic is_jump(input logic [INSTR_W_DEF-1:0] word);
    return is_ctrl(word) && !word[HALT_BIT];
  endfunction

endpackage : cpu_pkg

// File: rtl/fetch_sequencer.sv
// Program sequencer: owns the pc, fetches from the instruction ROM, resolves
// JUMP/HALT locally and hands every other instruction to the datapath.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic               stop,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  state_e             state_q,   state_d;
  logic [ADDR_W-1:0]  pc_q,      pc_d;
  logic [INSTR_W-1:0] instr_q,   instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic fetch_jump;
  logic fetch_halt;

  assign fetch_jump = is_jump(imem_data);
  assign fetch_halt = is_halt(imem_data);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end

      FETCH: begin
        instr_d = imem_data;
        if (fetch_jump) begin
          // A self-targeting JUMP spins here; stop is the only graceful exit.
          pc_d = imem_data[ADDR_W-1:0];
          if (stop) state_d = IDLE;
        end else if (fetch_halt) begin
          state_d = HALT;
        end else begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // valid is held until accepted; stop only matters once the handshake lands.
        if (instr_ready) begin
          retired_d = retired_q + 1'b1;
          pc_d      = pc_q + 1'b1;
          state_d   = stop ? IDLE : FETCH;
        end
      end

      HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      // NOTE: non-blocking so all flops update from the same pre-edge values.
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ISSUE);
  assign busy        = (state_q == FETCH) || (state_q == ISSUE);
  assign halted      = (state_q == HALT);
  assign retired     = retired_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// programs compared against a program-walking reference model.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       instr_ready = 1'b0;
  logic [4:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] instr;
  logic       instr_valid;
  logic       busy;
  logic       halted;
  logic [7:0] retired;

  logic [7:0] rom [32];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] hs_instr [$];
  int         hs_edge  [$];

  logic [7:0] exp_instr [$];
  int         exp_off   [$];
  int         exp_end_pc;

  fetch_sequencer dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .stop        (stop),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .halted      (halted),
    .retired     (retired)
  );

  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;

  // Handshake log: instruction and edge index of every accepted transfer.
  always @(posedge clk) begin
    if (clear && instr_valid && instr_ready) begin
      hs_instr.push_back(instr);
      hs_edge.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    clear = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    instr_ready = 1'b0;
    step();
    step();
    clear = 1'b1;
    hs_instr.delete();
    hs_edge.delete();
  endtask

  // Returns the index of the edge that samples start.
  task automatic pulse_start(output int t);
    t = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 32; i++) rom[i] = v;
  endtask

  function automatic logic [7:0] rand_dp_op();
    logic [1:0] op;
    logic [5:0] lo;
    op = 2'($urandom_range(0, 2));
    lo = 6'($urandom);
    return {op, lo};
  endfunction

  // Walks the program from start_pc: each issued instruction costs two cycles
  // (fetch + issue) and each JUMP one cycle. Offsets are in edges after the
  // edge that sampled start, assuming ready is always high.
  task automatic model_run(input int start_pc, input int max_issue);
    int pc;
    int f;
    int steps;
    logic [7:0] w;
    exp_instr.delete();
    exp_off.delete();
    exp_end_pc = -1;
    pc = start_pc;
    f = 1;
    steps = 0;
    while (exp_instr.size() < max_issue && steps < 2000) begin
      steps++;
      w = rom[pc];
      if (w[7:6] == 2'b11) begin
        if (w[5]) begin
          exp_end_pc = pc;
          return;
        end
        pc = int'(w[4:0]);
        f += 1;
      end else begin
        exp_instr.push_back(w);
        exp_off.push_back(f + 1);
        pc = (pc + 1) % 32;
        f += 2;
      end
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    for (int i = 0; i < budget && !instr_valid; i++) step();
    n_checks++;
    if (instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: instr_valid not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_halted(input int budget, input string name);
    for (int i = 0; i < budget && !halted; i++) step();
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: halted not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget && busy; i++) step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: busy still high after %0d cycles", name, budget);
    end
  endtask

  task automatic check_stream(input string name, input int t, input bit timed);
    n_checks++;
    if (hs_instr.size() != exp_instr.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d handshakes, expected %0d", name, hs_instr.size(), exp_instr.size());
    end
    for (int i = 0; i < hs_instr.size() && i < exp_instr.size(); i++) begin
      n_checks++;
      if (hs_instr[i] !== exp_instr[i]) begin
        n_fail++;
        $display("FAIL %s_instr[%0d]: got %02h, expected %02h", name, i, hs_instr[i], exp_instr[i]);
      end
      if (timed) begin
        n_checks++;
        if (hs_edge[i] - t != exp_off[i]) begin
          n_fail++;
          $display("FAIL %s_time[%0d]: got +%0d cycles, expected +%0d", name, i, hs_edge[i] - t, exp_off[i]);
        end
      end
    end
  endtask

  task automatic test_reset;
    do_reset();
    clear = 1'b0;
    #1;
    n_checks++;
    if ({instr_valid, busy, halted} !== 3'b000 || imem_addr !== 5'd0 || instr !== 8'h00 || retired !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: valid/busy/halted=%b%b%b addr=%0d instr=%02h retired=%0d, expected 000 0 00 0",
               instr_valid, busy, halted, imem_addr, instr, retired);
    end
    clear = 1'b1;
  endtask

  task automatic test_basic;
    int t;
    do_reset();
    fill_rom(8'hE0);
    rom[0] = 8'h44; rom[1] = 8'h49; rom[2] = 8'h18; rom[3] = 8'hE0;
    instr_ready = 1'b1;
    model_run(0, 100);
    pulse_start(t);
    wait_halted(40, "basic_halt");
    check_stream("basic", t, 1'b1);
    n_checks++;
    if (retired !== 8'd3 || imem_addr !== 5'(exp_end_pc) || busy !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: retired=%0d addr=%0d busy=%b valid=%b, expected 3 %0d 0 0",
               retired, imem_addr, busy, instr_valid, exp_end_pc);
    end
    // Restart from HALT: pc back to 0, retired kept.
    pulse_start(t);
    n_checks++;
    if (busy !== 1'b1 || halted !== 1'b0 || imem_addr !== 5'd0 || retired !== 8'd3) begin
      n_fail++;
      $display("FAIL halt_restart: busy=%b halted=%b addr=%0d retired=%0d, expected 1 0 0 3",
               busy, halted, imem_addr, retired);
    end
    wait_halted(40, "restart_halt");
    n_checks++;
    if (retired !== 8'd6) begin
      n_fail++;
      $display("FAIL restart_retired: got %0d, expected 6", retired);
    end
  endtask

  task automatic test_backpressure;
    int t;
    do_reset();
    fill_rom(8'hE0);
    rom[0] = 8'h44; rom[1] = 8'h49; rom[2] = 8'h18;
    instr_ready = 1'b0;
    pulse_start(t);
    wait_valid(5, "bp_valid");
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== 8'h44 || imem_addr !== 5'd0 || retired !== 8'd0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b instr=%02h addr=%0d retired=%0d, expected 1 44 0 0",
                 k, instr_valid, instr, imem_addr, retired);
      end
      step();
    end
    instr_ready = 1'b1;
    step();
    n_checks++;
    if (imem_addr !== 5'd1 || retired !== 8'd1 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: addr=%0d retired=%0d valid=%b, expected 1 1 0", imem_addr, retired, instr_valid);
    end
  endtask

  task automatic test_jump_loop;
    int t;
    int n;
    do_reset();
    fill_rom(8'hE0);
    rom[0] = 8'h89; rom[1] = 8'hC0;
    instr_ready = 1'b1;
    pulse_start(t);
    for (int i = 0; i < 900 && hs_instr.size() < 257; i++) step();
    n_checks++;
    if (hs_instr.size() < 257) begin
      n_fail++;
      $display("FAIL jump_progress: got %0d issues, expected at least 257", hs_instr.size());
    end
    stop = 1'b1;
    wait_idle(10, "jump_stop");
    stop = 1'b0;
    n = hs_instr.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (hs_instr[i] !== 8'h89 || hs_edge[i] - t != 2 + 3 * i) begin
        n_fail++;
        $display("FAIL jump_issue[%0d]: instr=%02h at +%0d, expected 89 at +%0d", i, hs_instr[i], hs_edge[i] - t, 2 + 3 * i);
      end
    end
    n_checks++;
    if (retired !== 8'(n % 256) || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_retired: retired=%0d halted=%b, expected %0d 0", retired, halted, n % 256);
    end
  endtask

  task automatic test_stop_issue;
    int t;
    logic [7:0] w0, w1;
    do_reset();
    for (int i = 0; i < 32; i++) rom[i] = rand_dp_op();
    w0 = rom[0];
    w1 = rom[0];
    instr_ready = 1'b0;
    pulse_start(t);
    wait_valid(5, "stop_valid");
    stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== w0) begin
        n_fail++;
        $display("FAIL stop_hold[%0d]: valid=%b instr=%02h, expected 1 %02h", k, instr_valid, instr, w0);
      end
    end
    instr_ready = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 5'd1 || retired !== 8'd1 || hs_instr.size() != 1) begin
      n_fail++;
      $display("FAIL stop_idle: busy=%b valid=%b addr=%0d retired=%0d issues=%0d, expected 0 0 1 1 1",
               busy, instr_valid, imem_addr, retired, hs_instr.size());
    end
    // start with stop still high: one instruction from address 0, then idle.
    pulse_start(t);
    n_checks++;
    if (busy !== 1'b1 || imem_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL stop_restart: busy=%b addr=%0d, expected 1 0", busy, imem_addr);
    end
    wait_idle(10, "stop_second");
    n_checks++;
    if (retired !== 8'd2 || imem_addr !== 5'd1 || hs_instr.size() != 2) begin
      n_fail++;
      $display("FAIL stop_second_end: retired=%0d addr=%0d issues=%0d, expected 2 1 2", retired, imem_addr, hs_instr.size());
    end else begin
      n_checks++;
      if (hs_instr[1] !== w1 || hs_edge[1] - t != 2) begin
        n_fail++;
        $display("FAIL stop_second_issue: instr=%02h at +%0d, expected %02h at +2", hs_instr[1], hs_edge[1] - t, w1);
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_wrap;
    int t;
    int max_addr;
    do_reset();
    fill_rom(8'h44);
    instr_ready = 1'b1;
    max_addr = 0;
    pulse_start(t);
    for (int i = 0; i < 80 && hs_instr.size() < 32; i++) begin
      if (int'(imem_addr) > max_addr) max_addr = int'(imem_addr);
      step();
    end
    n_checks++;
    if (hs_instr.size() != 32 || imem_addr !== 5'd0 || retired !== 8'd32 || halted !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_end: issues=%0d addr=%0d retired=%0d halted=%b busy=%b, expected 32 0 32 0 1",
               hs_instr.size(), imem_addr, retired, halted, busy);
    end
    n_checks++;
    if (max_addr != 31) begin
      n_fail++;
      $display("FAIL wrap_top: highest address %0d, expected 31", max_addr);
    end
    if (hs_edge.size() >= 32) begin
      n_checks++;
      if (hs_edge[31] - t != 64) begin
        n_fail++;
        $display("FAIL wrap_rate: 32nd issue at +%0d, expected +64", hs_edge[31] - t);
      end
    end
  endtask

  task automatic test_async_reset;
    int t;
    do_reset();
    for (int i = 0; i < 32; i++) rom[i] = rand_dp_op();
    instr_ready = 1'b1;
    pulse_start(t);
    for (int i = 0; i < 7; i++) step();
    instr_ready = 1'b0;
    wait_valid(5, "areset_valid");
    #2;
    clear = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 5'd0 || retired !== 8'd0 || busy !== 1'b0 || instr !== 8'h00) begin
      n_fail++;
      $display("FAIL areset_now: valid=%b addr=%0d retired=%0d busy=%b instr=%02h, expected 0 0 0 0 00",
               instr_valid, imem_addr, retired, busy, instr);
    end
    start = 1'b1;
    step();
    step();
    n_checks++;
    if (busy !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_start: busy=%b valid=%b while clear low, expected 0 0", busy, instr_valid);
    end
    start = 1'b0;
    #2;
    clear = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0 || imem_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL areset_release: busy=%b addr=%0d, expected 0 0", busy, imem_addr);
    end
  endtask

  task automatic test_random;
    int t;
    int halt_at;
    for (int it = 0; it < 6; it++) begin
      halt_at = $urandom_range(6, 31);
      for (int pc = 0; pc < 32; pc++) begin
        if (pc == 31 || pc == halt_at) begin
          rom[pc] = {3'b111, 5'($urandom)};
        end else if ($urandom_range(0, 4) == 0 && pc < 30) begin
          rom[pc] = {3'b110, 5'($urandom_range(pc + 1, 31))};
        end else begin
          rom[pc] = rand_dp_op();
        end
      end
      do_reset();
      model_run(0, 100);
      pulse_start(t);
      for (int i = 0; i < 400 && !halted; i++) begin
        instr_ready = ($urandom_range(0, 3) != 0);
        // start while busy must be ignored
        start = busy ? 1'($urandom) : 1'b0;
        step();
      end
      start = 1'b0;
      n_checks++;
      if (halted !== 1'b1 || imem_addr !== 5'(exp_end_pc) || retired !== 8'(exp_instr.size())) begin
        n_fail++;
        $display("FAIL rand%0d_end: halted=%b addr=%0d retired=%0d, expected 1 %0d %0d",
                 it, halted, imem_addr, retired, exp_end_pc, exp_instr.size());
      end
      check_stream("rand", t, 1'b0);
    end
  endtask

  initial begin
    fill_rom(8'h00);
    test_reset();
    test_basic();
    test_backpressure();
    test_jump_loop();
    test_stop_issue();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_sequencer

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program sequencer for the 32 x 8-bit instruction ROM. Owns the program counter, drives the ROM address, and latches each instruction word. Resolves JUMP and HALT internally. Presents every other instruction to the datapath over a valid/ready handshake. Sits between the instruction ROM (combinational read) and the CPU decode/execute datapath.

Parameters:
ADDR_W, 5, ROM address width (depth = 2**ADDR_W = 32)
INSTR_W, 8, instruction width
CNT_W, 8, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
clear  in  1  reset, asynchronous, active-low
start  in  1  pulse: begin execution at address 0 (honoured in IDLE or HALT only)
stop  in  1  level: return to IDLE after the current handshake completes
imem_addr  out  ADDR_W  ROM address (equals pc)
imem_data  in  INSTR_W  ROM read data, combinational from imem_addr
instr  out  INSTR_W  latched instruction for datapath
instr_valid  out  1  instr is valid
instr_ready  in  1  datapath accepts instr
busy  out  1  state is FETCH or ISSUE
halted  out  1  state is HALT
retired  out  CNT_W  count of instructions handed to datapath, wraps

Behaviour:
- Reset (clear low, asynchronous) forces the following values: state=IDLE, pc=0, instr=0, instr_valid=0, busy=0, halted=0, retired=0. Behaviour with clear low mid-operation is identical; any pending issue is dropped.
- Opcode is instr[7:6]. Opcode 2'b11 is a control instruction:
  - instr[5]=1 → HALT.
  - instr[5]=0 → JUMP, target = instr[4:0].
  - Opcodes 00, 01 and 10 are datapath instructions.
- State IDLE:
  - instr_valid=0.
  - start=1 → pc<=0, go to FETCH.
- State FETCH (one cycle):
  - instr<=imem_data.
  - Opcode decoded from imem_data in the same cycle.
  - JUMP → pc<=target, stay FETCH. Nothing is issued and retired is unchanged.
  - HALT → go to HALT. pc holds the HALT address.
  - Otherwise → go to ISSUE.
- State ISSUE:
  - instr_valid=1; instr held stable until handshake.
  - On instr_valid & instr_ready: retired<=retired+1 and pc<=pc+1 (31 wraps to 0).
  - After the handshake, go to IDLE if stop=1, else FETCH.
  - No handshake → remain in ISSUE. valid never drops without a handshake, even if stop rises.
- State HALT:
  - halted=1, instr_valid=0.
  - start=1 → pc<=0, retired unchanged, go to FETCH.
- Latency and throughput:
  - start sampled at edge t gives FETCH in cycle t+1 (imem_addr=0) and instr_valid in cycle t+2.
  - Sustained throughput with ready held high: 1 instruction per 2 cycles.
  - Each JUMP adds 1 cycle.
- Simultaneous and boundary events:
  - start while busy is ignored.
  - stop in IDLE or HALT has no effect.
  - start and stop both high in IDLE → FETCH. stop then takes effect after the first handshake.
  - A JUMP to its own address loops in FETCH indefinitely; only clear or stop can end it. stop is checked in FETCH on a JUMP: stop=1 → IDLE.
- imem_addr is always pc; the output is registered-derived with no combinational path from inputs.

Decomposition:
- Shared package cpu_pkg holds the following:
  - OP_CTRL=2'b11 and the HALT bit index 5.
  - ADDR_W and INSTR_W defaults.
  - State encoding enum {IDLE, FETCH, ISSUE, HALT}.
  - Function is_jump/is_halt(instr).
- Single module; no sub-module is warranted. The pc/retired counters stay inline.

Test Plan:
1. Basic program sequence:
   - ROM[0..2]=8'h44,8'h49,8'h18; ROM[3]=8'hE0 (HALT); ready=1; pulse start.
   - Required: instr_valid first high 2 cycles after start.
   - Required: 44, 49 and 18 issued in order, each 2 cycles apart.
   - Required: then halted=1, retired=3, imem_addr=3.
2. Back-pressure:
   - Same ROM; ready=0 for 5 cycles while valid is high.
   - Required: instr=8'h44 stable and valid held for all 5 cycles.
   - Required: pc unchanged until ready=1, then advances to 1.
3. JUMP and loop:
   - ROM[0]=8'h89, ROM[1]=8'hC0 (JUMP 0), ready=1.
   - Required: 8'h89 issued repeatedly, every 3 cycles.
   - Required: 8'hC0 is never on instr_valid.
   - Required: retired increments per issue and wraps 255→0.
4. stop during ISSUE with ready=0:
   - Required: valid stays high.
   - Required: after ready, the handshake completes and state→IDLE (busy=0), pc=next address.
   - Then start → fetch restarts at address 0.
5. Wrap-around:
   - ROM all 8'h44; run 32 issues.
   - Required: imem_addr goes 31→0 without halt.
   - Required: retired=32.
6. Asynchronous reset mid-ISSUE:
   - Drive clear low between clock edges.
   - Required: instr_valid=0, pc=0, retired=0 immediately, without a clock.
   - Required: start ignored while clear is low.
